// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address.
// SCL/SDA are synchronized into the clk domain. START and STOP conditions and
// SCL edges are detected there, and a byte-level FSM handles addressing,
// write data capture and read data return over an open-drain SDA pad.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] data16,
  input  logic [7:0]  tx_data,
  output logic        tx_load,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_IGNORE    = 3'd7;

  // Synchronizer chains plus one delayed copy for edge detection.
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        ack_seen_q, ack_seen_d;
  logic        ctrl_ack_q, ctrl_ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] data16_q, data16_d;
  logic        tx_load_q, tx_load_d;
  logic        busy_q, busy_d;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  byte_in;

  // Two-flop synchronizers and the delayed copies used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  // SCL must be stably high across the SDA transition for START/STOP.
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  // Byte as it stands once the current SDA bit is shifted in (MSB first).
  assign byte_in   = {shift_q[6:0], sda_sync_q};

  // Next-state and datapath logic for the protocol FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_seen_d = ack_seen_q;
    ctrl_ack_d = ctrl_ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    data16_d   = data16_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;

    if (start_det) begin
      // START or repeated START always restarts address reception.
      state_d    = ST_ADDR;
      cnt_d      = 3'd0;
      sda_oe_d   = 1'b0;
      ack_seen_d = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      cnt_d      = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        // First SCL fall drives the ACK; the second one ends the ACK slot.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_data[7];
              cnt_d     = 3'd0;
              state_d   = ST_READ;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = ST_WRITE;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              data16_d   = {data16_q[7:0], byte_in};
              rx_valid_d = 1'b1;
              state_d    = ST_WRITE_ACK;
            end else begin
              state_d = ST_WRITE;
            end
          end else begin
            state_d = ST_WRITE;
          end
        end

        ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WRITE;
            end
          end else begin
            state_d = ST_WRITE_ACK;
          end
        end

        // The controller samples on SCL rise; the next bit is shown on SCL fall.
        ST_READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d    = ST_READ_ACK;
              ack_seen_d = 1'b0;
            end else begin
              state_d = ST_READ;
            end
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b1};
            sda_oe_d = ~shift_q[6];
          end else begin
            state_d = ST_READ;
          end
        end

        // Release SDA, sample the controller's ACK, then reload or give up.
        ST_READ_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
            ctrl_ack_d = ~sda_sync_q;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_oe_d = 1'b0;
            end else if (ctrl_ack_q) begin
              shift_d    = tx_data;
              tx_load_d  = 1'b1;
              sda_oe_d   = ~tx_data[7];
              cnt_d      = 3'd0;
              ack_seen_d = 1'b0;
              state_d    = ST_READ;
            end else begin
              sda_oe_d   = 1'b0;
              ack_seen_d = 1'b0;
              state_d    = ST_IGNORE;
            end
          end else begin
            state_d = ST_READ_ACK;
          end
        end

        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      ctrl_ack_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      data16_q   <= 16'd0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_seen_q <= ack_seen_d;
      ctrl_ack_q <= ctrl_ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      data16_q   <= data16_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign data16   = data16_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-banged controller drives the bus,
// expected write results and read-data feeds are queued, and a monitor
// checks every rx_valid / tx_load pulse against the queues.
module tb_i2c_target;

  localparam int QC = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_ctl, sda_ctl;
  logic        scl_i, sda_i;
  logic        sda_oe;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] data16;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int txl_cnt = 0;
  logic oe_seen = 1'b0;

  logic [23:0] exp_rx[$];   // {rx_data, data16}
  logic [7:0]  tx_feed[$];  // byte to present after each tx_load

  // Open-drain bus: the target can only pull SDA low.
  assign scl_i = scl_ctl;
  assign sda_i = sda_ctl & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .data16(data16),
    .tx_data(tx_data), .tx_load(tx_load), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: score each output pulse against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          check("unexpected_rx_valid", 32'd1, 32'd0);
        end else begin
          logic [23:0] e;
          e = exp_rx.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e[23:16]});
          check("data16", {16'd0, data16}, {16'd0, e[15:0]});
        end
      end
      if (tx_load) begin
        txl_cnt++;
        if (tx_feed.size() == 0) begin
          check("unexpected_tx_load", 32'd1, 32'd0);
        end else begin
          tx_data = tx_feed.pop_front();
        end
      end
    end
  end

  task automatic wq();
    repeat (QC) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_ctl = 1'b1; wq();
    scl_ctl = 1'b1; wq();
    sda_ctl = 1'b0; wq();
    scl_ctl = 1'b0; wq();
  endtask

  task automatic stop_cond();
    sda_ctl = 1'b0; wq();
    scl_ctl = 1'b1; wq();
    sda_ctl = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b, output logic r);
    sda_ctl = b;    wq();
    scl_ctl = 1'b1; wq();
    r = sda_i;      wq();
    scl_ctl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(~ack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         rx0, tx0;

    rst = 1'b1; scl_ctl = 1'b1; sda_ctl = 1'b1; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_data16", {16'd0, data16}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_load", {31'd0, tx_load}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wq();

    // Write 0x00, 0x45 to 0x50.
    start_cond();
    write_byte(8'hA0, ack);
    check("w_addr_ack", {31'd0, ack}, 32'd1);
    check("w_busy", {31'd0, busy}, 32'd1);
    exp_rx.push_back({8'h00, 16'h0000});
    write_byte(8'h00, ack);
    check("w_data0_ack", {31'd0, ack}, 32'd1);
    exp_rx.push_back({8'h45, 16'h0045});
    write_byte(8'h45, ack);
    check("w_data1_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    check("w_busy_after_stop", {31'd0, busy}, 32'd0);
    check("w_data16_final", {16'd0, data16}, 32'h0045);
    check("w_rx_count", rx_cnt, 32'd2);

    // Address 0x51: no response.
    oe_seen = 1'b0; rx0 = rx_cnt;
    start_cond();
    write_byte(8'hA2, ack);
    check("nomatch_ack", {31'd0, ack}, 32'd0);
    check("nomatch_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("nomatch_busy", {31'd0, busy}, 32'd0);
    check("nomatch_rx", rx_cnt - rx0, 32'd0);
    stop_cond();

    // Read A5 (ACK), 3C (NACK), then IGNORE until STOP.
    tx_data = 8'hA5; tx0 = txl_cnt;
    tx_feed.push_back(8'h3C);
    tx_feed.push_back(8'h00);
    start_cond();
    write_byte(8'hA1, ack);
    check("r_addr_ack", {31'd0, ack}, 32'd1);
    read_byte(d, 1'b1);
    check("r_byte0", {24'd0, d}, 32'h0A5);
    read_byte(d, 1'b0);
    check("r_byte1", {24'd0, d}, 32'h03C);
    read_byte(d, 1'b0);
    check("r_ignore_released", {24'd0, d}, 32'h0FF);
    check("r_tx_load_count", txl_cnt - tx0, 32'd2);
    stop_cond();
    check("r_busy_after_stop", {31'd0, busy}, 32'd0);

    // Write 0x12, repeated START, read 5A.
    start_cond();
    write_byte(8'hA0, ack);
    check("rs_waddr_ack", {31'd0, ack}, 32'd1);
    exp_rx.push_back({8'h12, 16'h4512});
    write_byte(8'h12, ack);
    check("rs_wdata_ack", {31'd0, ack}, 32'd1);
    tx_data = 8'h5A;
    tx_feed.push_back(8'h00);
    start_cond();
    check("rs_busy_held", {31'd0, busy}, 32'd1);
    write_byte(8'hA1, ack);
    check("rs_raddr_ack", {31'd0, ack}, 32'd1);
    read_byte(d, 1'b0);
    check("rs_rbyte", {24'd0, d}, 32'h05A);
    check("rs_data16_low", {24'd0, data16[7:0]}, 32'h012);
    stop_cond();

    // Reset in the middle of a read while the target pulls SDA low.
    tx_data = 8'h00;
    tx_feed.push_back(8'h00);
    start_cond();
    write_byte(8'hA1, ack);
    check("rst_mid_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, r);
    check("rst_mid_oe_before", {31'd0, sda_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe_async", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_data16", {16'd0, data16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sda_ctl = 1'b1;
    wq();
    start_cond();
    write_byte(8'hA0, ack);
    check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd1);

    // Full byte 0x3C, then STOP after four bits of the next byte.
    exp_rx.push_back({8'h3C, 16'h003C});
    write_byte(8'h3C, ack);
    check("part_first_ack", {31'd0, ack}, 32'd1);
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b1, r);
    stop_cond();
    check("part_busy", {31'd0, busy}, 32'd0);
    check("part_data16", {16'd0, data16}, 32'h003C);
    check("part_rx", rx_cnt - rx0, 32'd0);
    start_cond();
    write_byte(8'hA0, ack);
    check("part_next_addr_ack", {31'd0, ack}, 32'd1);
    exp_rx.push_back({8'h99, 16'h3C99});
    write_byte(8'h99, ack);
    check("part_next_data_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    wq();

    check("exp_rx_drained", exp_rx.size(), 32'd0);
    check("tx_feed_drained", tx_feed.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
